// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational Fetch lookup,
// Execute-stage resolve/update, mispredict redirect and saturating statistics.
module branch_predictor #(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PC_WIDTH-1:0]  PCF_i,
  output logic                 PredTakenF_o,
  output logic [PC_WIDTH-1:0]  PredTargetF_o,
  input  logic                 BranchE_i,
  input  logic                 JumpE_i,
  input  logic                 TakenE_i,
  input  logic [PC_WIDTH-1:0]  PCE_i,
  input  logic [PC_WIDTH-1:0]  PCTargetE_i,
  input  logic [PC_WIDTH-1:0]  PCPlus4E_i,
  input  logic                 PredTakenE_i,
  input  logic [PC_WIDTH-1:0]  PredTargetE_i,
  input  logic                 StatClr_i,
  output logic                 MispredictE_o,
  output logic [PC_WIDTH-1:0]  RedirectPCE_o,
  output logic [CNT_WIDTH-1:0] BranchCount_o,
  output logic [CNT_WIDTH-1:0] MispredCount_o
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;

  logic [ENTRIES-1:0]  validTab;
  logic [ENTRIES-1:0]  jumpTab;
  logic [1:0]          ctrTab    [ENTRIES];
  logic [TAG_W-1:0]    tagTab    [ENTRIES];
  logic [PC_WIDTH-1:0] targetTab [ENTRIES];

  function automatic logic [1:0] ctrInc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctrDec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cntSatInc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Fetch: combinational lookup
  logic [IDX-1:0]   idxF;
  logic [TAG_W-1:0] tagF;
  logic             hitF;

  assign idxF          = PCF_i[IDX+1:2];
  assign tagF          = PCF_i[PC_WIDTH-1:IDX+2];
  assign hitF          = validTab[idxF] && (tagTab[idxF] == tagF);
  assign PredTakenF_o  = rst_i && hitF && (ctrTab[idxF][1] || jumpTab[idxF]);
  assign PredTargetF_o = PredTakenF_o ? targetTab[idxF] : PCF_i + PC_WIDTH'(4);

  // Execute: resolve, mispredict detection and update decisions
  logic [IDX-1:0]   idxE;
  logic [TAG_W-1:0] tagE;
  logic             hitE, resolveE, allocE, bumpE, dropE, killE;

  assign idxE     = PCE_i[IDX+1:2];
  assign tagE     = PCE_i[PC_WIDTH-1:IDX+2];
  assign hitE     = validTab[idxE] && (tagTab[idxE] == tagE);
  assign resolveE = BranchE_i || JumpE_i;
  assign allocE   = resolveE && TakenE_i && !hitE;
  assign bumpE    = resolveE && TakenE_i && hitE;
  assign dropE    = resolveE && !TakenE_i && hitE;
  // A predicted-taken non-branch means a stale alias; evict it
  assign killE    = !resolveE && PredTakenE_i && hitE;

  assign MispredictE_o = rst_i &&
    ((resolveE && ((TakenE_i != PredTakenE_i) ||
                   (TakenE_i && (PredTargetE_i != PCTargetE_i)))) ||
     (!resolveE && PredTakenE_i));
  assign RedirectPCE_o = (resolveE && TakenE_i) ? PCTargetE_i : PCPlus4E_i;

  logic unusedPcBits;
  assign unusedPcBits = ^{PCF_i[1:0], PCE_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      validTab <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrTab[i] <= 2'b00;
    end else begin
      if (allocE) begin
        validTab[idxE] <= 1'b1;
        ctrTab[idxE]   <= JumpE_i ? 2'b11 : 2'b10;
      end else if (bumpE) begin
        ctrTab[idxE] <= ctrInc(ctrTab[idxE]);
      end else if (dropE) begin
        ctrTab[idxE] <= ctrDec(ctrTab[idxE]);
      end else if (killE) begin
        validTab[idxE] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (allocE) begin
      tagTab[idxE]    <= tagE;
      targetTab[idxE] <= PCTargetE_i;
      jumpTab[idxE]   <= JumpE_i;
    end else if (bumpE) begin
      targetTab[idxE] <= PCTargetE_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      BranchCount_o  <= '0;
      MispredCount_o <= '0;
    end else if (StatClr_i) begin
      BranchCount_o  <= '0;
      MispredCount_o <= '0;
    end else begin
      if (resolveE)      BranchCount_o  <= cntSatInc(BranchCount_o);
      if (MispredictE_o) MispredCount_o <= cntSatInc(MispredCount_o);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CNT_WIDTH=4).
module tb_branch_predictor;

  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] pcF;
  logic          predTakenF;
  logic [PW-1:0] predTargetF;
  logic          branchE, jumpE, takenE, predTakenE, statClr;
  logic [PW-1:0] pcE, pcTargetE, pcPlus4E, predTargetE;
  logic          mispredictE;
  logic [PW-1:0] redirectPcE;
  logic [CW-1:0] branchCount, mispredCount;

  always #5 clk = ~clk;

  branch_predictor #(.PC_WIDTH(PW), .ENTRIES(16), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_n), .PCF_i(pcF),
    .PredTakenF_o(predTakenF), .PredTargetF_o(predTargetF),
    .BranchE_i(branchE), .JumpE_i(jumpE), .TakenE_i(takenE),
    .PCE_i(pcE), .PCTargetE_i(pcTargetE), .PCPlus4E_i(pcPlus4E),
    .PredTakenE_i(predTakenE), .PredTargetE_i(predTargetE),
    .StatClr_i(statClr), .MispredictE_o(mispredictE),
    .RedirectPCE_o(redirectPcE), .BranchCount_o(branchCount),
    .MispredCount_o(mispredCount)
  );

  typedef enum int {S_PT, S_PTGT, S_MIS, S_RED, S_BC, S_MC} sel_t;
  typedef struct {
    string         tag;
    sel_t          sel;
    logic [PW-1:0] exp;
  } exp_t;

  exp_t sbQ[$];
  int   nCompared = 0;
  int   nMismatch = 0;

  task automatic checkVal(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] obsSel(input sel_t s);
    case (s)
      S_PT:    return PW'(predTakenF);
      S_PTGT:  return predTargetF;
      S_MIS:   return PW'(mispredictE);
      S_RED:   return redirectPcE;
      S_BC:    return PW'(branchCount);
      default: return PW'(mispredCount);
    endcase
  endfunction

  task automatic push(input string tag, input sel_t s, input logic [PW-1:0] e);
    exp_t x;
    x.tag = tag; x.sel = s; x.exp = e;
    sbQ.push_back(x);
  endtask

  task automatic pushCounts(input string tag, input int bc, input int mc);
    push({tag, "_branchCnt"}, S_BC, PW'(bc));
    push({tag, "_mispredCnt"}, S_MC, PW'(mc));
  endtask

  task automatic drv(input logic br, input logic jmp, input logic tk,
                     input logic [PW-1:0] pce, input logic [PW-1:0] tgt,
                     input logic pt, input logic [PW-1:0] ptgt,
                     input logic [PW-1:0] pcf, input logic clr);
    branchE = br; jumpE = jmp; takenE = tk; pcE = pce; pcTargetE = tgt;
    pcPlus4E = pce + 32'd4; predTakenE = pt; predTargetE = ptgt;
    pcF = pcf; statClr = clr;
  endtask

  task automatic idle(input logic [PW-1:0] pcf);
    drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, pcf, 1'b0);
  endtask

  // Sample mid-cycle, drain the scoreboard, then step to just past the next edge
  task automatic drain();
    exp_t x;
    @(negedge clk);
    while (sbQ.size() > 0) begin
      x = sbQ.pop_front();
      checkVal(x.tag, obsSel(x.sel), x.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 32'h100, 1'b0);
    push("rst_predTaken", S_PT, 0);
    push("rst_predTarget", S_PTGT, 32'h104);
    push("rst_mispredict", S_MIS, 0);
    pushCounts("rst", 0, 0);
    drain();
    rst_n = 1'b1;

    // Taken branch at 0x100 with no prediction; same-cycle lookup sees old table
    drv(1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104, 32'h100, 1'b0);
    push("alloc_mispredict", S_MIS, 1);
    push("alloc_redirect", S_RED, 32'h80);
    push("alloc_sameCycleLookup", S_PT, 0);
    drain();

    idle(32'h100);
    push("hit_predTaken", S_PT, 1);
    push("hit_predTarget", S_PTGT, 32'h80);
    pushCounts("afterAlloc", 1, 1);
    drain();

    idle(32'h140);
    push("alias_predTaken", S_PT, 0);
    push("alias_predTarget", S_PTGT, 32'h144);
    drain();

    // Not taken while predicted taken: ctr 10 -> 01
    drv(1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80, 32'h100, 1'b0);
    push("ntk_mispredict", S_MIS, 1);
    push("ntk_redirect", S_RED, 32'h104);
    drain();

    idle(32'h100);
    push("weak_predTaken", S_PT, 0);
    push("weak_predTarget", S_PTGT, 32'h104);
    pushCounts("afterNtk", 2, 2);
    drain();

    // Correctly predicted taken: ctr 01 -> 10
    drv(1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80, 32'h0, 1'b0);
    push("correct_mispredict", S_MIS, 0);
    push("correct_redirect", S_RED, 32'h80);
    drain();

    idle(32'h100);
    push("retrain_predTaken", S_PT, 1);
    push("retrain_predTarget", S_PTGT, 32'h80);
    drain();

    // Taken to a new target: target mismatch, target refreshed, ctr -> 11
    drv(1'b1, 1'b0, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80, 32'h0, 1'b0);
    push("tgtMiss_mispredict", S_MIS, 1);
    push("tgtMiss_redirect", S_RED, 32'h90);
    drain();

    idle(32'h100);
    push("refresh_predTarget", S_PTGT, 32'h90);
    pushCounts("afterRefresh", 4, 3);
    drain();

    // Non-branch predicted taken: redirect and evict
    drv(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h90, 32'h100, 1'b0);
    push("nonBr_mispredict", S_MIS, 1);
    push("nonBr_redirect", S_RED, 32'h104);
    push("nonBr_sameCycleLookup", S_PT, 1);
    drain();

    idle(32'h100);
    push("evicted_predTaken", S_PT, 0);
    push("evicted_predTarget", S_PTGT, 32'h104);
    pushCounts("afterEvict", 4, 4);
    drain();

    // Jump allocates strongly taken
    drv(1'b0, 1'b1, 1'b1, 32'h204, 32'h300, 1'b0, 32'h208, 32'h0, 1'b0);
    push("jump_mispredict", S_MIS, 1);
    push("jump_redirect", S_RED, 32'h300);
    drain();

    idle(32'h204);
    push("jump_predTaken", S_PT, 1);
    push("jump_predTarget", S_PTGT, 32'h300);
    pushCounts("afterJump", 5, 5);
    drain();

    // Not-taken misses: no allocation, counter saturates
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 1'b0, 1'b0, 32'h400, 32'h500, 1'b0, 32'h404, 32'h400, 1'b0);
      if (i == 0) begin
        push("ntMiss_mispredict", S_MIS, 0);
        push("ntMiss_noAllocLookup", S_PT, 0);
      end
      drain();
    end

    idle(32'h400);
    push("ntMiss_noAlloc", S_PT, 0);
    pushCounts("saturated", 15, 5);
    drain();

    drv(1'b1, 1'b0, 1'b1, 32'h400, 32'h500, 1'b0, 32'h404, 32'h0, 1'b1);
    drain();

    idle(32'h0);
    pushCounts("statClr", 0, 0);
    drain();

    // Asynchronous reset in the middle of an allocating cycle
    drv(1'b1, 1'b0, 1'b1, 32'h208, 32'h600, 1'b0, 32'h20c, 32'h204, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("midRst_predTakenAsync", PW'(predTakenF), 0);
    checkVal("midRst_mispredict", PW'(mispredictE), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(32'h208);
    push("midRst_noAlloc", S_PT, 0);
    push("midRst_predTarget", S_PTGT, 32'h20c);
    pushCounts("midRst", 0, 0);
    drain();

    idle(32'h204);
    push("midRst_jumpCleared", S_PT, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
